// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of pending stores between the MEM stage and
// data memory. Stores drain to memory in program order whenever no load owns
// the memory port. Loads see pending stores through byte-wise forwarding from
// the youngest matching entry.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       st_req,
  input  logic [31:0]                st_addr,
  input  logic [3:0]                 st_be,
  input  logic [31:0]                st_wd,
  input  logic [31:0]                st_pc,
  input  logic                       ld_req,
  input  logic [31:0]                ld_addr,
  input  logic [31:0]                dm_rd,
  output logic                       dm_we,
  output logic [3:0]                 dm_be,
  output logic [31:0]                dm_addr,
  output logic [31:0]                dm_wd,
  output logic [31:0]                dm_pc,
  output logic [31:0]                ld_data,
  output logic                       stall,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; contents are not reset, only the pointers and count.
  logic [29:0]   r_addr [DEPTH];
  logic [3:0]    r_be   [DEPTH];
  logic [31:0]   r_wd   [DEPTH];
  logic [31:0]   r_pc   [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_st_valid;
  logic          w_push;
  logic          w_drain;
  logic [31:0]   w_ld_data;
  logic          w_unused;

  // Byte-offset bits of both addresses are architecturally ignored.
  assign w_unused = &{1'b0, st_addr[1:0], ld_addr[1:0]};

  // Full/empty come from the registered count, so a drain this cycle cannot
  // make room for a push in the same cycle.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_st_valid = st_req & (st_be != 4'b0000);
  assign w_push     = w_st_valid & ~w_full & ~Reset;
  assign w_drain    = ~w_empty & ~ld_req & ~Reset;

  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;
  // A zero-byte-enable store is a no-op and never holds the pipeline.
  assign stall   = w_st_valid & w_full & ~Reset;

  assign dm_we   = w_drain;
  assign dm_addr = w_drain ? {r_addr[r_head], 2'b00} : ld_addr;
  assign dm_be   = w_drain ? r_be[r_head] : 4'b0000;
  assign dm_wd   = w_drain ? r_wd[r_head] : 32'h0000_0000;
  assign dm_pc   = w_drain ? r_pc[r_head] : 32'h0000_0000;
  assign ld_data = w_ld_data;

  // Write the incoming store into the tail slot.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr[31:2];
      r_be[r_tail]   <= st_be;
      r_wd[r_tail]   <= st_wd;
      r_pc[r_tail]   <= st_pc;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards pending stores.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + {{(PW-1){1'b0}}, 1'b1};
      end
      if (w_drain) begin
        r_head <= r_head + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest hit wins
  // per byte; the store arriving this cycle is not yet in the array.
  always_comb begin
    logic [PW-1:0] v_idx;
    logic          v_hit;
    w_ld_data = dm_rd;
    v_idx     = r_head;
    v_hit     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_head + PW'(i);
      v_hit = (CW'(i) < r_count) && (r_addr[v_idx] == ld_addr[31:2]);
      for (int k = 0; k < 4; k++) begin
        w_ld_data[8*k +: 8] = (v_hit && r_be[v_idx][k]) ? r_wd[v_idx][8*k +: 8]
                                                        : w_ld_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  logic        Clk;
  logic        Reset;
  logic        st_req;
  logic [31:0] st_addr;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [31:0] st_pc;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] dm_rd;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] ld_data;
  logic        stall;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  store_buffer #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .st_req(st_req), .st_addr(st_addr), .st_be(st_be), .st_wd(st_wd), .st_pc(st_pc),
    .ld_req(ld_req), .ld_addr(ld_addr), .dm_rd(dm_rd),
    .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
    .ld_data(ld_data), .stall(stall), .full(full), .empty(empty), .count(count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] pc);
    st_req = 1'b1; st_addr = a; st_be = be; st_wd = wd; st_pc = pc;
  endtask

  initial begin
    Reset = 1'b1; st_req = 1'b0; st_addr = 32'h0; st_be = 4'h0; st_wd = 32'h0;
    st_pc = 32'h0; ld_req = 1'b0; ld_addr = 32'h0; dm_rd = 32'h0;

    // Reset: outputs forced quiet even with a store request present.
    tick(); tick();
    st_req = 1'b1; st_be = 4'hF;
    settle();
    chk("rst_we", {31'b0, dm_we}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    st_req = 1'b0; st_be = 4'h0;
    tick();
    Reset = 1'b0;
    settle();
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);

    // Single word store, written the cycle after the push.
    push(32'h10, 4'hF, 32'hDEADBEEF, 32'h100);
    settle();
    chk("sw_push_we", {31'b0, dm_we}, 32'd0);
    tick();
    st_req = 1'b0;
    settle();
    chk("sw_we", {31'b0, dm_we}, 32'd1);
    chk("sw_addr", dm_addr, 32'h10);
    chk("sw_wd", dm_wd, 32'hDEADBEEF);
    chk("sw_be", {28'b0, dm_be}, 32'hF);
    chk("sw_pc", dm_pc, 32'h100);
    tick();
    settle();
    chk("sw_empty", {31'b0, empty}, 32'd1);
    chk("sw_we_after", {31'b0, dm_we}, 32'd0);

    // Fill while a load holds the port; then overflow and drain in order.
    ld_req = 1'b1; ld_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      push(32'h40 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 32'h200 + 32'(4*i));
      settle();
      chk("fill_we", {31'b0, dm_we}, 32'd0);
      tick();
    end
    push(32'h50, 4'hF, 32'hA4, 32'h210);
    settle();
    chk("fill_count", {29'b0, count}, 32'd4);
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("ovf_stall", {31'b0, stall}, 32'd1);
    tick();
    settle();
    chk("ovf_count", {29'b0, count}, 32'd4);
    ld_req = 1'b0;
    settle();
    chk("ovf_stall_drain", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", {31'b0, dm_we}, 32'd1);
      chk("drain_addr", dm_addr, 32'h40 + 32'(4*i));
      chk("drain_wd", dm_wd, 32'hA0 + 32'(i));
      tick();
      st_req = 1'b0;
      settle();
      if (i == 0) chk("drain_count", {29'b0, count}, 32'd3);
    end
    chk("drain_empty", {31'b0, empty}, 32'd1);

    // Byte-wise forwarding, youngest entry wins.
    ld_req = 1'b1; ld_addr = 32'h20; dm_rd = 32'h11223344;
    push(32'h20, 4'b0011, 32'h0000BBCC, 32'h300);
    settle();
    chk("fwd_same_cycle", ld_data, 32'h11223344);
    tick();
    push(32'h20, 4'b0001, 32'h000000AA, 32'h304);
    settle();
    chk("fwd_one", ld_data, 32'h1122BBCC);
    tick();
    st_req = 1'b0;
    settle();
    chk("fwd_two", ld_data, 32'h1122BBAA);
    ld_addr = 32'h24;
    settle();
    chk("fwd_miss", ld_data, 32'h11223344);
    chk("fwd_ld_addr", dm_addr, 32'h24);
    ld_req = 1'b0;
    settle();
    chk("fwd_drain_be", {28'b0, dm_be}, 32'h3);
    tick(); tick();
    settle();
    chk("fwd_empty", {31'b0, empty}, 32'd1);

    // Interleaved push/drain across pointer wrap.
    for (int i = 0; i < 7; i++) begin
      if (i < 6) push(32'h100 + 32'(4*i), 4'hF, 32'h5000 + 32'(i), 32'h400);
      else st_req = 1'b0;
      settle();
      chk("il_count", {29'b0, count}, (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("il_addr", dm_addr, 32'h100 + 32'(4*(i-1)));
      chk("il_we", {31'b0, dm_we}, (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    settle();
    chk("il_empty", {31'b0, empty}, 32'd1);

    // Reset with pending stores discards them.
    ld_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(32'h200 + 32'(4*i), 4'hF, 32'h7 + 32'(i), 32'h500);
      tick();
    end
    st_req = 1'b0; ld_req = 1'b0; Reset = 1'b1;
    settle();
    chk("rp_count_pre", {29'b0, count}, 32'd3);
    chk("rp_we", {31'b0, dm_we}, 32'd0);
    tick();
    Reset = 1'b0;
    settle();
    chk("rp_empty", {31'b0, empty}, 32'd1);
    chk("rp_we_after", {31'b0, dm_we}, 32'd0);
    tick();
    settle();
    chk("rp_we_later", {31'b0, dm_we}, 32'd0);

    // Zero byte-enable store is ignored.
    push(32'h300, 4'h0, 32'hFFFF, 32'h600);
    settle();
    chk("be0_stall", {31'b0, stall}, 32'd0);
    tick();
    st_req = 1'b0;
    settle();
    chk("be0_count", {29'b0, count}, 32'd0);
    chk("be0_we", {31'b0, dm_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 SHALL have port Clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port st_req  input  1  MEM-stage store request.
REQ-005 SHALL have port st_addr  input  32  store byte address; bits [1:0] ignored.
REQ-006 SHALL have port st_be  input  4  store byte enables.
REQ-007 SHALL have port st_wd  input  32  store data, already byte-lane aligned.
REQ-008 SHALL have port st_pc  input  32  PC of the store instruction.
REQ-009 SHALL have port ld_req  input  1  MEM-stage load request.
REQ-010 SHALL have port ld_addr  input  32  load byte address.
REQ-011 SHALL have port dm_rd  input  32  combinational read data from data memory.
REQ-012 SHALL have port dm_we  output  1  data memory write enable.
REQ-013 SHALL have port dm_be  output  4  data memory byte enables.
REQ-014 SHALL have port dm_addr  output  32  data memory address.
REQ-015 SHALL have port dm_wd  output  32  data memory write data.
REQ-016 SHALL have port dm_pc  output  32  PC forwarded to data memory for write logging.
REQ-017 SHALL have port ld_data  output  32  load word after store-to-load forwarding.
REQ-018 SHALL have port stall  output  1  store rejected; upstream holds.
REQ-019 SHALL have port full  output  1  count == DEPTH.
REQ-020 SHALL have port empty  output  1  count == 0.
REQ-021 SHALL have port count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-022 SHALL hold a circular FIFO with head/tail pointers modulo DEPTH; each entry = {addr[31:2], be, wd, pc}.
REQ-023 SHALL enqueue at tail on the rising edge when st_req=1, st_be!=0 and full=0.
REQ-024 SHALL ignore st_req with st_be==0 (no enqueue, no stall).
REQ-025 SHALL drive stall = st_req & full combinationally; full uses registered count, so a drain in the same cycle does not free a slot for that cycle's push.
REQ-026 SHALL, when empty=0 and ld_req=0, drive dm_we=1, dm_addr={head.addr,2'b00}, dm_be/dm_wd/dm_pc from the head entry, and advance head on that rising edge.
REQ-027 SHALL, when ld_req=1, drive dm_we=0 and dm_addr=ld_addr, pausing drain that cycle.
REQ-028 SHALL drive dm_we=0 when empty=1; dm_addr then equals ld_addr.
REQ-029 SHALL give minimum push-to-write latency of 1 cycle; a store pushed into an empty buffer is never written in its push cycle.
REQ-030 SHALL update count as +1 on push-only, -1 on drain-only, unchanged on push and drain together.
REQ-031 SHALL form each ld_data byte k from the youngest entry with addr matching ld_addr[31:2] and be[k]=1, else from dm_rd byte k.
REQ-032 SHALL exclude a store pushed in the same cycle from forwarding; simultaneous st_req and ld_req enqueues the store and serves the load.
REQ-033 SHALL write stores to memory strictly in program order.

Reset
REQ-034 SHALL, when Reset is high at a rising edge, clear head, tail and count to 0, discarding pending stores.
REQ-035 SHALL force dm_we=0 and stall=0 combinationally while Reset is high.
REQ-036 SHALL present empty=1, full=0, count=0 after reset; entry contents need not be cleared.

Verification
REQ-037 SHALL cover: reset, sw 0x10 be=1111 wd=0xDEADBEEF -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF; following cycle empty=1.
REQ-038 SHALL cover: ld_req held, 4 stores -> count=4, full=1; fifth st_req -> stall=1, count stays 4; drop ld_req -> 4 writes in order on 4 cycles.
REQ-039 SHALL cover: sh 0x20 be=0011 wd=0xBBCC, then sb 0x20 be=0001 wd=0xAA, ld_req ld_addr=0x20, dm_rd=0x11223344 -> ld_data=0x1122BBAA.
REQ-040 SHALL cover: 6 interleaved push/drain pairs with DEPTH=4 -> pointers wrap, dm_addr order equals push order, count never exceeds 1.
REQ-041 SHALL cover: 3 pending entries, Reset pulsed -> dm_we=0 that cycle, empty=1 after, no further writes.
REQ-042 SHALL cover: st_req with st_be=0 -> count unchanged, stall=0, no dm_we.
